// File: rtl/pe_pkg.sv
// Shared constants and types for the PE register-write arbiter.
package pe_pkg;

    localparam int unsigned PE_DATA_W       = 32;
    localparam int unsigned PE_MAX_NUM_REQ  = 8;
    localparam int unsigned PE_MAX_NUM_REGS = 16;
    localparam int unsigned PE_STALL_CNT_W  = 16;

    typedef logic [PE_STALL_CNT_W-1:0] stall_cnt_t;

endpackage

// File: rtl/pe_reg_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Walk ptr, ptr+1, ... with wrap at NUM_REQ-1, taking the first request seen.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ)) begin
                sum = sum - (PW+1)'(NUM_REQ);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_reg_write_arbiter.sv
// Round-robin write arbiter driving one-hot register load enables and shared write data.
// Optional per-requester stall counters are built when PE_WRARB_STALL_CNT_EN is defined.
module pe_reg_write_arbiter
    import pe_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned DATA_W   = PE_DATA_W
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 stall,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*$clog2(NUM_REGS)-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]            req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REGS-1:0]                  reg_en,
    output logic [DATA_W-1:0]                    reg_wdata,
    output logic                                 addr_err
`ifdef PE_WRARB_STALL_CNT_EN
    ,
    output logic [NUM_REQ*PE_STALL_CNT_W-1:0]    stall_cnt
`endif
);

    localparam int unsigned AW = $clog2(NUM_REGS);
    localparam int unsigned PW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > PE_MAX_NUM_REQ) begin : g_bad_num_req
        $error("NUM_REQ out of range");
    end
    if (NUM_REGS < 2 || NUM_REGS > PE_MAX_NUM_REGS) begin : g_bad_num_regs
        $error("NUM_REGS out of range");
    end

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      ptr_nxt;
    logic [NUM_REQ-1:0] req_elig;
    logic [NUM_REQ-1:0] grant;
    logic               gnt_any;
    logic [PW-1:0]      gnt_idx;
    logic [AW-1:0]      sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               addr_ok;

    // Stall and reset both suppress eligibility so no handshake can complete.
    assign req_elig = (stall || reset) ? '0 : req_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req_elig),
        .ptr   (ptr),
        .grant (grant)
    );

    assign req_ready = grant;
    assign gnt_any   = |grant;

    // Encode the one-hot grant and select the winning address and data.
    always_comb begin
        gnt_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx  = PW'(i);
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign addr_ok = ({1'b0, sel_addr} < (AW+1)'(NUM_REGS));
    assign ptr_nxt = (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            reg_en    <= '0;
            reg_wdata <= '0;
            addr_err  <= 1'b0;
        end else begin
            reg_en   <= '0;
            addr_err <= 1'b0;
            if (gnt_any) begin
                ptr       <= ptr_nxt;
                reg_wdata <= sel_data;
                if (addr_ok) begin
                    reg_en <= NUM_REGS'(1) << sel_addr;
                end else begin
                    addr_err <= 1'b1;
                end
            end
        end
    end

`ifdef PE_WRARB_STALL_CNT_EN
    stall_cnt_t cnt_q [NUM_REQ];

    // Count cycles a requester waits while valid; saturate rather than wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !req_ready[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign stall_cnt[g*PE_STALL_CNT_W +: PE_STALL_CNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_pe_reg_write_arbiter.sv
// Scoreboard bench for pe_reg_write_arbiter (4 requesters, 6 registers).
module tb_pe_reg_write_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned NG = 6;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              stall;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [NG-1:0]     reg_en;
    logic [DW-1:0]     reg_wdata;
    logic              addr_err;
`ifdef PE_WRARB_STALL_CNT_EN
    logic [NR*16-1:0]  stall_cnt;
`endif

    pe_reg_write_arbiter #(
        .NUM_REQ  (NR),
        .NUM_REGS (NG),
        .DATA_W   (DW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .stall     (stall),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .reg_en    (reg_en),
        .reg_wdata (reg_wdata),
        .addr_err  (addr_err)
`ifdef PE_WRARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int            cyc;
        logic [NR-1:0] ready;
    } grant_t;

    typedef struct {
        int            cyc;
        logic [NG-1:0] en;
        logic [DW-1:0] wdata;
        logic          err;
    } load_t;

    grant_t gq[$];
    load_t  lq[$];
    int     cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every visible grant or register load is popped and compared.
    always @(negedge clock) begin
        if (req_ready != '0) begin
            vectors++;
            if (gq.size() == 0) begin
                miscompares++;
                $display("FAIL grant_unexpected cyc=%0d ready=%b required none", cyc, req_ready);
            end else begin
                grant_t g;
                g = gq.pop_front();
                if (g.cyc != cyc || g.ready !== req_ready) begin
                    miscompares++;
                    $display("FAIL grant cyc=%0d ready=%b required cyc=%0d ready=%b",
                             cyc, req_ready, g.cyc, g.ready);
                end
            end
        end
        if (reg_en != '0 || addr_err) begin
            vectors++;
            if (lq.size() == 0) begin
                miscompares++;
                $display("FAIL load_unexpected cyc=%0d en=%b err=%b required none", cyc, reg_en, addr_err);
            end else begin
                load_t l;
                l = lq.pop_front();
                if (l.cyc != cyc || l.en !== reg_en || l.wdata !== reg_wdata || l.err !== addr_err) begin
                    miscompares++;
                    $display("FAIL load cyc=%0d en=%b wdata=%h err=%b required cyc=%0d en=%b wdata=%h err=%b",
                             cyc, reg_en, reg_wdata, addr_err, l.cyc, l.en, l.wdata, l.err);
                end
            end
        end
    end

    task automatic cyc_go();
        @(posedge clock);
        #2;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]           = 1'b1;
        req_addr[i*AW +: AW]   = a;
        req_data[i*DW +: DW]   = d;
    endtask

    task automatic exp_grant(input int i);
        grant_t g;
        g.cyc   = cyc;
        g.ready = NR'(1) << i;
        gq.push_back(g);
    endtask

    task automatic exp_load(input logic [NG-1:0] en, input logic [DW-1:0] d, input logic err);
        load_t l;
        l.cyc   = cyc + 1;
        l.en    = en;
        l.wdata = d;
        l.err   = err;
        lq.push_back(l);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        stall     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;

        // Reset state, with all requesters valid to exercise the ready gate.
        repeat (3) cyc_go();
        req_valid = '1;
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_reg_en", 64'(reg_en), 64'h0);
        chk("rst_wdata", 64'(reg_wdata), 64'h0);
        chk("rst_addr_err", 64'(addr_err), 64'h0);

        // Single request, granted in the first cycle after reset release.
        cyc_go();
        reset     = 1'b0;
        req_valid = '0;
        set_req(2, 3'd5, 32'hDEADBEEF);
        exp_grant(2);
        exp_load(6'b100000, 32'hDEADBEEF, 1'b0);
        cyc_go();
        req_valid = '0;
        cyc_go();
        #1;
        chk("wdata_hold", 64'(reg_wdata), 64'hDEADBEEF);
        chk("reg_en_idle", 64'(reg_en), 64'h0);

        // Grant then reset before the load edge: no reg_en pulse, ptr back to 0.
        cyc_go();
        set_req(0, 3'd1, 32'h11111111);
        exp_grant(0);
        @(negedge clock);
        #2;
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) cyc_go();
        reset = 1'b0;
        set_req(1, 3'd2, 32'h22222222);
        set_req(3, 3'd3, 32'h33333333);
        exp_grant(1);
        exp_load(6'b000100, 32'h22222222, 1'b0);
        cyc_go();
        req_valid[1] = 1'b0;
        exp_grant(3);
        exp_load(6'b001000, 32'h33333333, 1'b0);
        cyc_go();
        req_valid = '0;

        // All four held valid after reset: 0,1,2,3,0,1,2,3 back to back.
        cyc_go();
        reset = 1'b1;
        cyc_go();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, AW'(i + 1), 32'hA0000000 + 32'(i));
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc_go();
            exp_grant(k % 4);
            exp_load(NG'(1) << ((k % 4) + 1), 32'hA0000000 + 32'(k % 4), 1'b0);
        end
        cyc_go();
        req_valid = '0;

        // Stall rises together with valid[1]; stall wins for three cycles.
        cyc_go();
        stall = 1'b1;
        set_req(1, 3'd4, 32'h55555555);
        #1;
        chk("stall_c0", 64'(req_ready), 64'h0);
        cyc_go();
        #1;
        chk("stall_c1", 64'(req_ready), 64'h0);
        cyc_go();
        #1;
        chk("stall_c2", 64'(req_ready), 64'h0);
        cyc_go();
        stall = 1'b0;
        exp_grant(1);
        exp_load(6'b010000, 32'h55555555, 1'b0);
        cyc_go();
        req_valid = '0;

        // Out-of-range addresses 7 and 6, then in-range address 0.
        cyc_go();
        set_req(2, 3'd7, 32'h77777777);
        exp_grant(2);
        exp_load(6'b000000, 32'h77777777, 1'b1);
        cyc_go();
        req_valid = '0;
        set_req(3, 3'd6, 32'h66666666);
        exp_grant(3);
        exp_load(6'b000000, 32'h66666666, 1'b1);
        cyc_go();
        req_valid = '0;
        set_req(0, 3'd0, 32'h00C0FFEE);
        exp_grant(0);
        exp_load(6'b000001, 32'h00C0FFEE, 1'b0);
        cyc_go();
        req_valid = '0;

        // Lone requester granted every cycle with fresh data.
        cyc_go();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) cyc_go();
            set_req(1, 3'd3, 32'hB0 + 32'(k));
            exp_grant(1);
            exp_load(6'b001000, 32'hB0 + 32'(k), 1'b0);
        end
        cyc_go();
        req_valid = '0;

`ifdef PE_WRARB_STALL_CNT_EN
        // Requester 3 waits through two stall cycles and grants to 0,1,2.
        cyc_go();
        reset = 1'b1;
        cyc_go();
        reset = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 3'd0, 32'(i));
        cyc_go();
        cyc_go();
        stall = 1'b0;
        exp_grant(0);
        exp_load(6'b000001, 32'd0, 1'b0);
        cyc_go();
        req_valid[0] = 1'b0;
        exp_grant(1);
        exp_load(6'b000001, 32'd1, 1'b0);
        cyc_go();
        req_valid[1] = 1'b0;
        exp_grant(2);
        exp_load(6'b000001, 32'd2, 1'b0);
        cyc_go();
        req_valid[2] = 1'b0;
        #1;
        chk("stall_cnt0", 64'(stall_cnt[15:0]), 64'd2);
        chk("stall_cnt2", 64'(stall_cnt[47:32]), 64'd4);
        chk("stall_cnt3", 64'(stall_cnt[63:48]), 64'd5);
        exp_grant(3);
        exp_load(6'b000001, 32'd3, 1'b0);
        cyc_go();
        stall = 1'b1;
        repeat (65540) cyc_go();
        #1;
        chk("stall_cnt3_sat", 64'(stall_cnt[63:48]), 64'hFFFF);
        cyc_go();
        stall = 1'b0;
        exp_grant(3);
        exp_load(6'b000001, 32'd3, 1'b0);
        cyc_go();
        req_valid = '0;
`endif

        repeat (3) cyc_go();
        while (gq.size() > 0) begin
            grant_t g;
            g = gq.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL grant_missing cyc=%0d ready=%b not seen", g.cyc, g.ready);
        end
        while (lq.size() > 0) begin
            load_t l;
            l = lq.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL load_missing cyc=%0d en=%b err=%b not seen", l.cyc, l.en, l.err);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
